// File: rtl/alu_slice_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_slice_pkg
// Desc   : Op-codes and compare codes shared by the ALU slice and its users.
// Rev    : 1.0
// ============================================================================
package alu_slice_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_POP = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_slice_popcount.sv
`default_nettype none
// ============================================================================
// Module : popcount
// Desc   : Combinational count of set bits in a W-bit word, W-bit result.
// Rev    : 1.0
// ============================================================================
module popcount #(
  parameter int W = 4
) (
  input  logic [W-1:0] in_bits,
  output logic [W-1:0] count
);

  // The count never exceeds W, so a W-bit accumulator cannot overflow.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + W'(in_bits[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_slice.sv
`default_nettype none
// ============================================================================
// Module : alu_slice
// Desc   : Registered S-bit ALU slice with carry/shift chaining and compare.
// Rev    : 1.0
// ============================================================================
module alu_slice
  import alu_slice_pkg::*;
#(
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic [2:0]   op,
  input  logic         p_c,
  output logic [S-1:0] out,
  output logic         n_c,
  output logic [1:0]   cmp
);

  logic [S-1:0] out_d, out_q;
  logic         n_c_d, n_c_q;
  logic [1:0]   cmp_d, cmp_q;
  logic [S:0]   sum;
  logic [S-1:0] pop;

  popcount #(.W(S)) u_popcount (
    .in_bits (a),
    .count   (pop)
  );

  assign sum = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, p_c};

  always_comb begin
    out_d = '0;
    n_c_d = 1'b0;
    cmp_d = CMP_EQ;
    case (op)
      OP_ADD: {n_c_d, out_d} = sum;
      OP_SHR: begin
        // Shifting the (S+1)-bit {p_c, a} keeps S=1 legal without slicing a[S-1:1].
        out_d = S'({p_c, a} >> 1);
        n_c_d = a[0];
      end
      OP_POP: out_d = pop;
      OP_CMP: begin
        if (a > b)      cmp_d = CMP_GT;
        else if (a < b) cmp_d = CMP_LT;
        else            cmp_d = CMP_EQ;
      end
      OP_AND: out_d = a & b;
      OP_OR:  out_d = a | b;
      OP_XOR: out_d = a ^ b;
      OP_NOT: out_d = ~a;
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      n_c_q <= 1'b0;
      cmp_q <= CMP_EQ;
    end else begin
      out_q <= out_d;
      n_c_q <= n_c_d;
      cmp_q <= cmp_d;
    end
  end

  assign out = out_q;
  assign n_c = n_c_q;
  assign cmp = cmp_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_slice.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_slice
// Desc   : Directed scoreboard bench for the 4-bit ALU slice.
// Rev    : 1.0
// ============================================================================
module tb_alu_slice;

  localparam int S = 4;

  typedef struct packed {
    logic [S-1:0] out;
    logic         n_c;
    logic [1:0]   cmp;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [S-1:0] a   = '0;
  logic [S-1:0] b   = '0;
  logic [2:0]   op  = 3'b000;
  logic         p_c = 1'b0;
  logic [S-1:0] out;
  logic         n_c;
  logic [1:0]   cmp;

  res_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  alu_slice #(.S(S)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .op  (op),
    .p_c (p_c),
    .out (out),
    .n_c (n_c),
    .cmp (cmp)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input res_t expv);
    res_t obs;
    obs = {out, n_c, cmp};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed out=%b n_c=%b cmp=%b, expected out=%b n_c=%b cmp=%b",
             tag, obs.out, obs.n_c, obs.cmp, expv.out, expv.n_c, expv.cmp);
    end
  endtask

  // Drive one op, queue its expected result, then check it exactly one edge later.
  task automatic step(input string tag, input logic [2:0] o, input logic [S-1:0] ia,
                      input logic [S-1:0] ib, input logic ipc, input res_t expv);
    res_t e;
    string t;
    op = o; a = ia; b = ib; p_c = ipc;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    compare(t, e);
  endtask

  initial begin
    logic [S-1:0] ra, rb;
    logic         rc;
    logic [S:0]   s5;
    logic [1:0]   rcmp;

    // Reset state
    op = 3'b000; a = 4'b1111; b = 4'b0001; rst = 1'b1;
    @(posedge clk); #1;
    compare("reset_init", '{4'b0000, 1'b0, 2'b00});

    rst = 1'b0;
    step("add_3_5",    3'b000, 4'b0011, 4'b0101, 1'b0, '{4'b1000, 1'b0, 2'b00});
    step("add_f_1",    3'b000, 4'b1111, 4'b0001, 1'b0, '{4'b0000, 1'b1, 2'b00});
    step("add_f_0_ci", 3'b000, 4'b1111, 4'b0000, 1'b1, '{4'b0000, 1'b1, 2'b00});
    step("shr_b_0",    3'b001, 4'b1011, 4'b0110, 1'b0, '{4'b0101, 1'b1, 2'b00});
    step("shr_b_1",    3'b001, 4'b1011, 4'b0110, 1'b1, '{4'b1101, 1'b1, 2'b00});
    step("shr_a_1",    3'b001, 4'b1010, 4'b0000, 1'b1, '{4'b1101, 1'b0, 2'b00});
    step("pop_0",      3'b010, 4'b0000, 4'b1111, 1'b1, '{4'b0000, 1'b0, 2'b00});
    step("pop_f",      3'b010, 4'b1111, 4'b0000, 1'b1, '{4'b0100, 1'b0, 2'b00});
    step("pop_b",      3'b010, 4'b1011, 4'b0000, 1'b0, '{4'b0011, 1'b0, 2'b00});
    step("cmp_gt",     3'b011, 4'b0101, 4'b0011, 1'b1, '{4'b0000, 1'b0, 2'b01});
    step("cmp_lt",     3'b011, 4'b0011, 4'b0101, 1'b0, '{4'b0000, 1'b0, 2'b10});
    step("cmp_eq",     3'b011, 4'b0110, 4'b0110, 1'b0, '{4'b0000, 1'b0, 2'b00});
    step("cmp_f_0",    3'b011, 4'b1111, 4'b0000, 1'b0, '{4'b0000, 1'b0, 2'b01});
    step("and",        3'b100, 4'b1100, 4'b1010, 1'b1, '{4'b1000, 1'b0, 2'b00});
    step("or",         3'b101, 4'b1100, 4'b1010, 1'b1, '{4'b1110, 1'b0, 2'b00});
    step("xor",        3'b110, 4'b1100, 4'b1010, 1'b1, '{4'b0110, 1'b0, 2'b00});
    step("not",        3'b111, 4'b1100, 4'b1010, 1'b1, '{4'b0011, 1'b0, 2'b00});
    // cmp must clear after a compare result
    step("cmp_gt2",    3'b011, 4'b1000, 4'b0001, 1'b0, '{4'b0000, 1'b0, 2'b01});
    step("add_after",  3'b000, 4'b0001, 4'b0001, 1'b0, '{4'b0010, 1'b0, 2'b00});

    // Mid-stream reset takes priority over an ADD that would carry
    op = 3'b000; a = 4'b1111; b = 4'b0001; p_c = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    compare("reset_mid", '{4'b0000, 1'b0, 2'b00});
    rst = 1'b0;
    #1;
    compare("reset_hold", '{4'b0000, 1'b0, 2'b00});
    @(posedge clk); #1;
    compare("reset_release", '{4'b0000, 1'b1, 2'b00});

    // Random ADD and CMP against arithmetic reference values
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      s5 = 5'(ra) + 5'(rb) + 5'(rc);
      step("rand_add", 3'b000, ra, rb, rc, '{s5[3:0], s5[4], 2'b00});
      rcmp = (ra > rb) ? 2'b01 : ((ra < rb) ? 2'b10 : 2'b00);
      step("rand_cmp", 3'b011, ra, rb, rc, '{4'b0000, 1'b0, rcmp});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
